// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU/DMA/memory signal bundle for the data memory arbiter
//
// Purpose: groups the CPU data port, the DMA loader port and the data memory
// port that meet at data_mem_arbiter.
// Modports:
//   master - arbiter side: takes requests and mem_rdata, drives acks, load
//            data, stall, busy and the memory strobe/address/data.
//   slave  - environment side: the requesters and the memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing the data memory between CPU and DMA
//
// Purpose: one memory transaction in flight at a time, granted round-robin
// between the CPU data port and the DMA loader port. Fixed memory read
// latency READ_LAT (cycles from the read mem_en cycle to valid mem_rdata).
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - data_mem_arbiter_if.master: cpu_*, dma_* request ports,
//            mem_* memory port, cpu_stall and busy status
module data_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_arbiter_if.master   bus
);
    localparam int CNT_W = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic               owner;        // 0 = CPU, 1 = DMA
    logic               last_grant;   // 0 = CPU, 1 = DMA
    logic [CNT_W-1:0]   cnt;
    logic               grant_dma;

    // DMA wins when it is the only requester, or on a tie when CPU had the last grant.
    assign grant_dma = bus.dma_req & (~bus.cpu_req | ~last_grant);

    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            bus.cpu_rdata <= '0;
            bus.dma_rdata <= '0;
            bus.cpu_ack   <= 1'b0;
            bus.dma_ack   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.cpu_ack <= 1'b0;
            bus.dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // The mem_* registers double as the request latch, so later
                    // changes on the requester inputs cannot leak into the access.
                    if (bus.cpu_req | bus.dma_req) begin
                        owner         <= grant_dma;
                        last_grant    <= grant_dma;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= grant_dma ? bus.dma_we    : bus.cpu_we;
                        bus.mem_addr  <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
                        bus.mem_wdata <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_en    <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                    if (bus.mem_we) begin
                        bus.cpu_ack <= ~owner;
                        bus.dma_ack <= owner;
                        state       <= RESP;
                    end else begin
                        cnt   <= CNT_W'(READ_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        if (owner) begin
                            bus.dma_rdata <= bus.mem_rdata;
                        end else begin
                            bus.cpu_rdata <= bus.mem_rdata;
                        end
                        bus.cpu_ack <= ~owner;
                        bus.dma_ack <= owner;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard testbench for data_mem_arbiter
module tb_data_mem_arbiter;
    localparam int READ_LAT = 2;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wiggle;
    } stim_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          start;
        logic        wiggle;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(READ_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    stim_t cpu_stim[$];
    stim_t dma_stim[$];
    exp_t  cpu_exp[$];
    exp_t  dma_exp[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem_m   [logic [31:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_en_cyc = -100;
    int en_since_ack = 0;
    int acc_cyc = 0;
    int rd_cnt = 0;
    logic [31:0] rd_addr;
    logic        acc_we;
    logic [31:0] acc_addr, acc_wdata;
    logic [31:0] cpu_rd_exp = 0, dma_rd_exp = 0;
    logic [31:0] cpu_rd_seen = 0, dma_rd_seen = 0;
    string grant_log = "";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic present(input bit dma);
        stim_t s;
        exp_t  e;
        bit    other_idle;
        if (dma) s = dma_stim.pop_front();
        else     s = cpu_stim.pop_front();
        e.we = s.we; e.addr = s.addr; e.wdata = s.wdata; e.wiggle = s.wiggle;
        if (s.we) begin
            ref_mem[s.addr] = s.wdata;
            e.rdata = dma ? dma_rd_exp : cpu_rd_exp;
        end else begin
            e.rdata = ref_rd(s.addr);
            if (dma) dma_rd_exp = e.rdata;
            else     cpu_rd_exp = e.rdata;
        end
        other_idle = dma ? (!bus.cpu_req && cpu_stim.size() == 0)
                         : (!bus.dma_req && dma_stim.size() == 0);
        e.lat   = (!bus.busy && other_idle) ? (s.we ? 2 : 2 + READ_LAT) : -1;
        e.start = cyc;
        if (dma) begin
            bus.dma_req = 1'b1; bus.dma_we = s.we; bus.dma_addr = s.addr; bus.dma_wdata = s.wdata;
            dma_exp.push_back(e);
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = s.we; bus.cpu_addr = s.addr; bus.cpu_wdata = s.wdata;
            cpu_exp.push_back(e);
        end
    endtask

    task automatic ack_seen(input bit dma);
        exp_t e;
        string p;
        p = dma ? "dma" : "cpu";
        if ((dma ? dma_exp.size() : cpu_exp.size()) == 0) begin
            check({p, "_unexpected_ack"}, 1, 0);
            return;
        end
        if (dma) e = dma_exp.pop_front();
        else     e = cpu_exp.pop_front();
        check({p, "_rdata"}, dma ? bus.dma_rdata : bus.cpu_rdata, e.rdata);
        check({p, "_mem_we"}, acc_we, e.we);
        check({p, "_mem_addr"}, acc_addr, e.addr);
        if (e.we) check({p, "_mem_wdata"}, acc_wdata, e.wdata);
        check({p, "_en_per_txn"}, en_since_ack, 1);
        check({p, "_en_to_ack"}, cyc - acc_cyc, e.we ? 1 : 1 + READ_LAT);
        if (e.lat >= 0) check({p, "_latency"}, cyc - e.start, e.lat);
        en_since_ack = 0;
        if (dma) dma_rd_seen = e.rdata;
        else     cpu_rd_seen = e.rdata;
        grant_log = {grant_log, dma ? "D" : "C"};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        // memory model: read data valid only in the cycle READ_LAT after the read strobe
        if (rd_cnt > 0) begin
            rd_cnt--;
            bus.mem_rdata = (rd_cnt == 0) ? mem_rd(rd_addr) : BAD;
        end else begin
            bus.mem_rdata = BAD;
        end
        if (bus.mem_en === 1'b1) begin
            check("mem_en_gap_ok", (cyc - last_en_cyc) >= 3, 1);
            last_en_cyc = cyc;
            en_since_ack++;
            acc_cyc = cyc; acc_we = bus.mem_we; acc_addr = bus.mem_addr; acc_wdata = bus.mem_wdata;
            if (bus.mem_we) mem_m[bus.mem_addr] = bus.mem_wdata;
            else begin rd_cnt = READ_LAT; rd_addr = bus.mem_addr; end
        end
        check("cpu_stall", bus.cpu_stall, bus.cpu_req & ~bus.cpu_ack);
        if (bus.cpu_ack === 1'b1) ack_seen(0);
        else check("cpu_rdata_hold", bus.cpu_rdata, cpu_rd_seen);
        if (bus.dma_ack === 1'b1) ack_seen(1);
        else check("dma_rdata_hold", bus.dma_rdata, dma_rd_seen);
        // requesters
        if (bus.cpu_req && bus.cpu_ack) begin
            if (cpu_stim.size() > 0) present(0); else bus.cpu_req = 1'b0;
        end else if (!bus.cpu_req && cpu_stim.size() > 0) present(0);
        if (bus.dma_req && bus.dma_ack) begin
            if (dma_stim.size() > 0) present(1); else bus.dma_req = 1'b0;
        end else if (!bus.dma_req && dma_stim.size() > 0) present(1);
        if (bus.cpu_req && !bus.cpu_ack && bus.busy && cpu_exp.size() > 0 && cpu_exp[0].wiggle) begin
            bus.cpu_addr  = ~cpu_exp[0].addr;
            bus.cpu_wdata = ~cpu_exp[0].wdata;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((cpu_stim.size() + dma_stim.size() + cpu_exp.size() + dma_exp.size()) > 0 && n < 300) begin
            step();
            n++;
        end
        check("drain_timeout", n < 300, 1);
        step();
        step();
    endtask

    task automatic push(input bit dma, input logic we, input logic [31:0] a, input logic [31:0] d, input logic w);
        stim_t s;
        s.we = we; s.addr = a; s.wdata = d; s.wiggle = w;
        if (dma) dma_stim.push_back(s);
        else     cpu_stim.push_back(s);
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'h1;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h88; bus.dma_wdata = 32'h2;
        bus.mem_rdata = BAD;

        // reset held with both requests high
        repeat (3) begin
            step();
            check("rst_mem_en", bus.mem_en, 0);
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_mem_addr", bus.mem_addr, 0);
            check("rst_mem_wdata", bus.mem_wdata, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_cpu_ack", bus.cpu_ack, 0);
            check("rst_dma_ack", bus.dma_ack, 0);
            check("rst_cpu_rdata", bus.cpu_rdata, 0);
            check("rst_dma_rdata", bus.dma_rdata, 0);
        end

        // both ports requesting from the first cycle after reset
        reset = 1'b0;
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        push(0, 0, 32'h100, 0, 0);
        push(0, 1, 32'h104, 32'hC0DE_0001, 0);
        push(1, 1, 32'h200, 32'hD00D_0002, 0);
        push(1, 0, 32'h204, 0, 0);
        present(0);
        present(1);
        drain();
        check("rr_order_cdcd", grant_log == "CDCD", 1);

        // CPU load, READ_LAT latency
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        mem_m[32'h10]   = 32'hDEAD_BEEF;
        push(0, 0, 32'h10, 0, 0);
        drain();
        check("cpu_ldr_rdata", cpu_rd_seen, 32'hDEAD_BEEF);

        // DMA store
        push(1, 1, 32'h20, 32'h1234, 0);
        drain();

        // CPU changes inputs after grant
        push(0, 1, 32'h30, 32'hAAAA_5555, 1);
        drain();
        push(0, 0, 32'h34, 0, 1);
        drain();
        push(0, 0, 32'h30, 0, 0);
        push(1, 0, 32'h20, 0, 0);
        drain();

        // mixed random traffic on disjoint address ranges
        for (int i = 0; i < 24; i++) begin
            push(i[0], $urandom_range(0, 1), (i[0] ? 32'h2000 : 32'h1000) + 4 * $urandom_range(0, 7),
                 $urandom, 0);
        end
        drain();

        // reset while a CPU read is in WAIT
        push(0, 0, 32'h40, 0, 0);
        t0 = last_en_cyc;
        for (int i = 0; i < 10 && last_en_cyc == t0; i++) step();
        check("rst_wait_issued", last_en_cyc != t0, 1);
        step();
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        cpu_stim.delete();
        cpu_exp.delete();
        rd_cnt = 0;
        en_since_ack = 0;
        cpu_rd_exp = 0; dma_rd_exp = 0;
        cpu_rd_seen = 0; dma_rd_seen = 0;
        step();
        check("rstw_busy", bus.busy, 0);
        check("rstw_cpu_ack", bus.cpu_ack, 0);
        check("rstw_cpu_rdata", bus.cpu_rdata, 0);
        check("rstw_mem_en", bus.mem_en, 0);
        reset = 1'b0;
        last_en_cyc = -100;
        step();
        check("rstw_no_ack", bus.cpu_ack, 0);
        push(0, 0, 32'h10, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
